// File: rtl/alu_isa_pkg.sv
// ISA definitions shared by the issue controller: field positions, opcodes,
// shift controls, condition codes and the condition evaluator.
package alu_isa_pkg;

    localparam int unsigned COND_HI = 31;
    localparam int unsigned COND_LO = 28;
    localparam int unsigned SR_HI   = 27;
    localparam int unsigned SR_LO   = 25;
    localparam int unsigned OP_HI   = 24;
    localparam int unsigned OP_LO   = 21;
    localparam int unsigned S_BIT   = 20;
    localparam int unsigned RD_HI   = 19;
    localparam int unsigned RD_LO   = 16;
    localparam int unsigned RS1_HI  = 15;
    localparam int unsigned RS1_LO  = 12;
    localparam int unsigned RS2_HI  = 11;
    localparam int unsigned RS2_LO  = 8;
    localparam int unsigned IMM_HI  = 15;
    localparam int unsigned IMM_LO  = 0;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;

    localparam logic [2:0] SR_NONE = 3'd0;
    localparam logic [2:0] SR_SRL4 = 3'd1;
    localparam logic [2:0] SR_SLL4 = 3'd2;
    localparam logic [2:0] SR_ROR4 = 3'd3;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    // Unlisted condition codes are never-true.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic pass;
        case (cond)
            COND_EQ: pass = nzcv[FLG_Z];
            COND_NE: pass = !nzcv[FLG_Z];
            COND_CS: pass = nzcv[FLG_C];
            COND_CC: pass = !nzcv[FLG_C];
            COND_MI: pass = nzcv[FLG_N];
            COND_PL: pass = !nzcv[FLG_N];
            COND_VS: pass = nzcv[FLG_V];
            COND_VC: pass = !nzcv[FLG_V];
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, ALU field/operand bus and writeback report of the
// issue controller. master is the controller, slave is its environment.
interface alu_issue_ctrl_if;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_word;
    logic [31:0] alu_r1;
    logic [31:0] alu_r2;
    logic [3:0]  alu_op_code;
    logic [3:0]  alu_cond;
    logic [2:0]  alu_sr_ctrl;
    logic        alu_s;
    logic [15:0] alu_imm;
    logic [3:0]  alu_flags;
    logic [32:0] alu_out;
    logic [3:0]  alu_flg;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_skip;
    logic        illegal;

    modport master (
        input  instr_valid, instr_word, alu_out, alu_flg,
        output instr_ready, alu_r1, alu_r2, alu_op_code, alu_cond, alu_sr_ctrl, alu_s,
               alu_imm, alu_flags, wb_valid, wb_rd, wb_data, wb_skip, illegal
    );

    modport slave (
        output instr_valid, instr_word, alu_out, alu_flg,
        input  instr_ready, alu_r1, alu_r2, alu_op_code, alu_cond, alu_sr_ctrl, alu_s,
               alu_imm, alu_flags, wb_valid, wb_rd, wb_data, wb_skip, illegal
    );

endinterface

// File: rtl/reg_file_16x32.sv
// Register file: two combinational read ports, one synchronous write port,
// asynchronous clear.
module reg_file_16x32 #(
    parameter int unsigned NREGS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr_a,
    input  logic [3:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the conditional ALU: decodes one instruction
// at a time, reads operands, waits ALU_LAT cycles, then retires to RF/NZCV.
module alu_issue_ctrl
    import alu_isa_pkg::*;
#(
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned NREGS   = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.master bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRead = 2'd1;
    localparam logic [1:0] StExec = 2'd2;
    localparam logic [1:0] StWb   = 2'd3;

    localparam logic [3:0] LastCnt = 4'(ALU_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] ir_q;
    logic [3:0]  cnt_q;
    logic [3:0]  nzcv_q;
    logic [31:0] r1_q, r2_q;
    logic [3:0]  flg_q;
    logic        wb_valid_q, wb_skip_q, illegal_q;
    logic [31:0] wb_data_q;

    logic [3:0]  ir_cond, ir_op, ir_rd, ir_rs1, ir_rs2;
    logic [2:0]  ir_sr;
    logic        ir_s;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic        accept, exec_done, legal, commit, rf_we;
    logic        unused_carry;

    assign ir_cond = ir_q[COND_HI:COND_LO];
    assign ir_sr   = ir_q[SR_HI:SR_LO];
    assign ir_op   = ir_q[OP_HI:OP_LO];
    assign ir_s    = ir_q[S_BIT];
    assign ir_rd   = ir_q[RD_HI:RD_LO];
    assign ir_rs1  = ir_q[RS1_HI:RS1_LO];
    assign ir_rs2  = ir_q[RS2_HI:RS2_LO];

    assign accept    = bus.instr_valid && (state_q == StIdle);
    assign exec_done = (state_q == StExec) && (cnt_q == LastCnt);
    assign legal     = (ir_op <= OP_XOR) && (ir_sr <= SR_ROR4);
    // NZCV cannot change between issue and here, so this is the value held at issue.
    assign commit    = legal && cond_pass(ir_cond, nzcv_q);
    assign rf_we     = wb_valid_q && !wb_skip_q;

    // The carry bit only reaches NZCV through alu_flg.
    assign unused_carry = bus.alu_out[32];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StRead;
            StRead:  state_d = StExec;
            StExec:  if (exec_done) state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ir_q    <= '0;
            cnt_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ir_q <= bus.instr_word;
            end
            if (state_q == StRead) begin
                r1_q  <= rf_rdata_a;
                r2_q  <= rf_rdata_b;
                cnt_q <= '0;
            end else if ((state_q == StExec) && !exec_done) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    // Writeback report is staged at the end of EXEC and lives exactly for the WB cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_skip_q  <= 1'b0;
            illegal_q  <= 1'b0;
            wb_data_q  <= '0;
            flg_q      <= '0;
            nzcv_q     <= '0;
        end else begin
            wb_valid_q <= exec_done;
            wb_skip_q  <= exec_done && !commit;
            illegal_q  <= exec_done && !legal;
            wb_data_q  <= (exec_done && commit) ? bus.alu_out[31:0] : '0;
            if (exec_done) begin
                flg_q <= bus.alu_flg;
            end
            if (rf_we && ir_s) begin
                nzcv_q <= flg_q;
            end
        end
    end

    reg_file_16x32 #(
        .NREGS (NREGS)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (ir_rd),
        .wdata   (wb_data_q),
        .raddr_a (ir_rs1),
        .raddr_b (ir_rs2),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    assign bus.instr_ready = (state_q == StIdle);
    assign bus.alu_r1      = r1_q;
    assign bus.alu_r2      = r2_q;
    assign bus.alu_op_code = ir_op;
    assign bus.alu_cond    = ir_cond;
    assign bus.alu_sr_ctrl = ir_sr;
    assign bus.alu_s       = ir_s;
    assign bus.alu_imm     = ir_q[IMM_HI:IMM_LO];
    assign bus.alu_flags   = nzcv_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = ir_rd;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_skip     = wb_skip_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: combinational ALU model, architectural reference
// model (register array + NZCV), scoreboard queue and writeback monitor.
module tb_alu_issue_ctrl;

    localparam int unsigned ALU_LAT = 2;

    localparam logic [3:0] AL = 4'he;
    localparam logic [3:0] EQ = 4'h0;
    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] ORR = 4'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(
        .ALU_LAT (ALU_LAT),
        .NREGS   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ALU stand-in: ADD also adds imm[7:0] so registers can be loaded from R0.
    function automatic logic [36:0] alu_fn(input logic [3:0] op, input logic [2:0] sr,
                                           input logic [7:0] imm8, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] r;
        logic [31:0] res;
        logic        v;
        v = 1'b0;
        case (op)
            4'd0: begin
                r = {1'b0, a} + {1'b0, b} + {25'd0, imm8};
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                r = {1'b0, a} - {1'b0, b};
                r[32] = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2: r = {1'b0, a * b};
            4'd3: r = {1'b0, a | b};
            4'd4: r = {1'b0, a & b};
            4'd5: r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        res = r[31:0];
        if (sr == 3'd1) res = res >> 4;
        else if (sr == 3'd2) res = res << 4;
        else if (sr == 3'd3) res = {res[3:0], res[31:4]};
        return {res[31], (res == 32'd0), r[32], v, r[32], res};
    endfunction

    assign {bus.alu_flg, bus.alu_out} = alu_fn(bus.alu_op_code, bus.alu_sr_ctrl,
                                               bus.alu_imm[7:0], bus.alu_r1, bus.alu_r2);

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        logic        skip;
        logic        ill;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  flags;
        logic [27:0] fields;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_rf[16];
    logic [3:0]  m_nzcv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Flag order {N,Z,C,V}; codes 0..7 pick Z,C,N,V in pairs, odd codes invert.
    function automatic logic m_pass(input logic [3:0] cond, input logic [3:0] f);
        logic sel;
        if (cond == 4'b1110) return 1'b1;
        if (cond[3]) return 1'b0;
        case (cond[2:1])
            2'd0: sel = f[2];
            2'd1: sel = f[1];
            2'd2: sel = f[3];
            default: sel = f[0];
        endcase
        return sel ^ cond[0];
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] cond, input logic [2:0] sr,
                                       input logic [3:0] op, input logic s, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [7:0] imm8);
        return {cond, sr, op, s, rd, rs1, rs2, imm8};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_nzcv = '0;
    endtask

    task automatic push_expected(input logic [31:0] w);
        exp_t        e;
        logic [36:0] alu;
        logic        legal, commit;
        legal    = (w[24:21] <= 4'd5) && (w[27:25] <= 3'd3);
        commit   = legal && m_pass(w[31:28], m_nzcv);
        e.rd     = w[19:16];
        e.r1     = m_rf[w[15:12]];
        e.r2     = m_rf[w[11:8]];
        alu      = alu_fn(w[24:21], w[27:25], w[7:0], e.r1, e.r2);
        e.data   = commit ? alu[31:0] : 32'd0;
        e.skip   = !commit;
        e.ill    = !legal;
        e.flags  = m_nzcv;
        e.fields = {w[31:20], w[15:0]};
        e.due    = cyc + int'(ALU_LAT) + 2;
        exp_q.push_back(e);
        if (commit) begin
            m_rf[e.rd] = alu[31:0];
            if (w[20]) m_nzcv = alu[36:33];
        end
    endtask

    task automatic issue(input logic [31:0] w, input bit hold);
        bit got;
        got = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr_word  = w;
        for (int t = 0; t < 64; t++) begin
            if (bus.instr_ready) begin
                chk("accept_while_busy", 64'(exp_q.size()), 64'd0);
                push_expected(w);
                @(posedge clk);
                #1;
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) chk("accept_timeout", 64'd0, 64'd1);
        if (!hold || !got) bus.instr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 64 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 64'(bus.instr_ready), 64'd1);
        chk({tag, "_wb"}, {bus.wb_valid, bus.wb_skip, bus.illegal, bus.wb_data}, 64'd0);
        chk({tag, "_flags"}, 64'(bus.alu_flags), 64'd0);
        chk({tag, "_ops"}, {bus.alu_r1, bus.alu_r2}, 64'd0);
        chk({tag, "_fields"}, {bus.alu_cond, bus.alu_sr_ctrl, bus.alu_op_code, bus.alu_s,
                               bus.alu_imm}, 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
                chk("wb_data", 64'(bus.wb_data), 64'(e.data));
                chk("wb_skip", 64'(bus.wb_skip), 64'(e.skip));
                chk("illegal", 64'(bus.illegal), 64'(e.ill));
                chk("alu_r1", 64'(bus.alu_r1), 64'(e.r1));
                chk("alu_r2", 64'(bus.alu_r2), 64'(e.r2));
                chk("alu_flags", 64'(bus.alu_flags), 64'(e.flags));
                chk("alu_fields", {bus.alu_cond, bus.alu_sr_ctrl, bus.alu_op_code, bus.alu_s,
                                   bus.alu_imm}, 64'(e.fields));
                chk("wb_latency", 64'(cyc), 64'(e.due));
                chk("ready_in_wb", 64'(bus.instr_ready), 64'd0);
            end
        end
    end

    initial begin
        int          seen;
        int          gap;
        logic [3:0]  cond, op;
        logic [2:0]  sr;
        bus.instr_valid = 1'b0;
        bus.instr_word  = '0;
        model_reset();
        #12;
        check_reset("init");
        @(negedge clk);
        rst = 1'b0;

        // Preload R1=5, R2=7, then R3=R1+R2 with flag update.
        issue(mk(AL, 3'd0, ADD, 1'b0, 4'd1, 4'd0, 4'd0, 8'd5), 1'b0);
        issue(mk(AL, 3'd0, ADD, 1'b0, 4'd2, 4'd0, 4'd0, 8'd7), 1'b0);
        issue(mk(AL, 3'd0, ADD, 1'b1, 4'd3, 4'd1, 4'd2, 8'd0), 1'b0);
        // EQ with Z clear skips; SUB R1-R1 sets Z; EQ then writes.
        issue(mk(EQ, 3'd0, ADD, 1'b1, 4'd4, 4'd1, 4'd2, 8'd0), 1'b0);
        issue(mk(AL, 3'd0, ORR, 1'b0, 4'd8, 4'd4, 4'd3, 8'd0), 1'b0);
        issue(mk(AL, 3'd0, SUB, 1'b1, 4'd7, 4'd1, 4'd1, 8'd0), 1'b0);
        issue(mk(EQ, 3'd0, ADD, 1'b0, 4'd4, 4'd1, 4'd2, 8'd0), 1'b0);
        // Illegal opcode and illegal shift control, both with s=1.
        issue(mk(AL, 3'd0, 4'd7, 1'b1, 4'd4, 4'd1, 4'd2, 8'd0), 1'b0);
        issue(mk(AL, 3'd4, ADD, 1'b1, 4'd4, 4'd1, 4'd2, 8'd0), 1'b0);
        issue(mk(AL, 3'd0, ORR, 1'b0, 4'd8, 4'd4, 4'd7, 8'd0), 1'b0);
        // Back-to-back with valid held, RAW on R5.
        issue(mk(AL, 3'd0, ADD, 1'b0, 4'd5, 4'd1, 4'd2, 8'd0), 1'b1);
        issue(mk(AL, 3'd0, ORR, 1'b0, 4'd6, 4'd5, 4'd5, 8'd0), 1'b0);
        issue(mk(AL, 3'd0, ADD, 1'b1, 4'd1, 4'd1, 4'd1, 8'd0), 1'b0);
        issue(mk(AL, 3'd0, ORR, 1'b0, 4'd0, 4'd6, 4'd1, 8'd0), 1'b0);
        drain();

        // Reset while the instruction sits in EXEC.
        issue(mk(AL, 3'd0, ADD, 1'b1, 4'd10, 4'd1, 4'd2, 8'd3), 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("rst_exec");
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (bus.wb_valid) seen++;
        end
        chk("wb_after_reset", 64'(seen), 64'd0);

        // s=0 keeps NZCV; a carry-out never reaches the register file.
        issue(mk(AL, 3'd0, ADD, 1'b0, 4'd1, 4'd0, 4'd0, 8'd1), 1'b0);
        issue(mk(AL, 3'd0, SUB, 1'b1, 4'd2, 4'd0, 4'd1, 8'd0), 1'b0);
        issue(mk(AL, 3'd0, ADD, 1'b0, 4'd9, 4'd2, 4'd2, 8'd0), 1'b0);
        issue(mk(AL, 3'd0, ORR, 1'b1, 4'd10, 4'd9, 4'd0, 8'd0), 1'b0);
        drain();

        for (int i = 0; i < 150; i++) begin
            cond = ($urandom_range(0, 1) == 0) ? AL : 4'($urandom_range(0, 15));
            op   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 5))
                                               : 4'($urandom_range(6, 15));
            sr   = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3))
                                               : 3'($urandom_range(4, 7));
            gap  = int'($urandom_range(0, 3));
            issue(mk(cond, sr, op, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     8'($urandom_range(0, 255))), gap == 0);
            repeat (gap) @(negedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
